// File: rtl/seg7_pkg.sv
// Shared constants and types for the scanned 7-segment display controller.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // BCD nibble reserved for "value out of range"; rendered as a dash.
  localparam logic [3:0] BCD_DASH = 4'hF;

  typedef enum logic [2:0] {
    CS_IDLE  = 3'd0,
    CS_LOAD  = 3'd1,
    CS_WAIT  = 3'd2,
    CS_STORE = 3'd3,
    CS_DONE  = 3'd4
  } conv_state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] pat;
    pat = SEG_BLANK;
    if (nib <= 4'd9) begin
      pat = SEG_DIGIT[nib];
    end else if (nib == BCD_DASH) begin
      pat = SEG_DASH;
    end
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
// Iterative double-dabble: one binary field to two BCD digits in FIELD_W shift cycles.
// Handshake: start is accepted only while busy is low; done pulses for one cycle and bcd/ovf then hold until the next accepted start.
module bin2bcd_seq #(
  parameter int FIELD_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FIELD_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [7:0]         bcd,
  output logic               ovf
);

  localparam int SW = FIELD_W + 8;

  logic [SW-1:0] sh;
  logic [SW-1:0] sh_adj;
  logic [2:0]    cnt;

  // Carries out of the tens nibble are dropped; values >= 100 are flagged by ovf instead.
  always_comb begin
    sh_adj = sh;
    if (sh[FIELD_W +: 4] >= 4'd5) begin
      sh_adj[FIELD_W +: 4] = sh[FIELD_W +: 4] + 4'd3;
    end
    if (sh[FIELD_W+4 +: 4] >= 4'd5) begin
      sh_adj[FIELD_W+4 +: 4] = sh[FIELD_W+4 +: 4] + 4'd3;
    end
  end

  assign bcd = sh[FIELD_W +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        sh   <= {8'h00, bin};
        cnt  <= 3'(FIELD_W);
        busy <= 1'b1;
        ovf  <= (int'(bin) >= 100);
      end else if (busy) begin
        sh  <= {sh_adj[SW-2:0], 1'b0};
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Scanned 7-segment controller: frame snapshot, sequential BCD conversion, digit strobing, 1 Hz field blink.
// Optional leading-zero blanking of the top field's tens digit with SEG7_LZB_EN.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W    = 6,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          seconds_clk,
  input  logic                          src_sel,
  input  logic [NUM_FIELDS*FIELD_W-1:0] time_val,
  input  logic [NUM_FIELDS*FIELD_W-1:0] sw_val,
  input  logic [NUM_FIELDS-1:0]         blink_mask,
  output logic [6:0]                    seg,
  output logic [2*NUM_FIELDS-1:0]       dig_en,
  output logic                          blink_phase,
  output conv_state_e                   conv_state
);

  localparam int ND  = 2 * NUM_FIELDS;
  localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW  = (ND > 1) ? $clog2(ND) : 1;
  localparam int FIW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int TW  = NUM_FIELDS * FIELD_W;

  if (FIELD_W < 4 || FIELD_W > 7) begin : g_chk_field_w
    $error("seg7_scan_display: FIELD_W must be in 4..7");
  end
  if (SCAN_DIV < 4) begin : g_chk_scan_div
    $error("seg7_scan_display: SCAN_DIV must be at least 4");
  end
  if (NUM_FIELDS * (FIELD_W + 3) >= ND * SCAN_DIV) begin : g_chk_conv_time
    $error("seg7_scan_display: conversion does not fit in one frame");
  end

  logic [PW-1:0]  presc;
  logic [DW-1:0]  d;
  logic           frame_start;
  logic [TW-1:0]  snap;
  logic [7:0]     work_buf    [NUM_FIELDS];
  logic [7:0]     display_buf [NUM_FIELDS];
  logic [FIW-1:0] conv_f;
  logic           conv_start;
  logic           conv_busy;
  logic           conv_done;
  logic [7:0]     conv_bcd;
  logic           conv_ovf;
  logic [NUM_FIELDS-1:0] mask_q;
  logic           sc_s1, sc_s2, sc_s3;
  logic [FIW-1:0] cur_f;
  logic [7:0]     cur_bcd;
  logic [3:0]     cur_nib;
  logic [6:0]     slot_seg;

  // Scan timebase: SCAN_DIV cycles per digit slot, ND slots per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      d     <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      d     <= (d == DW'(ND - 1)) ? '0 : d + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign frame_start = (presc == '0) && (d == '0);

  // Whole-source snapshot and display refresh happen together so fields never tear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) display_buf[i] <= 8'h00;
    end else if (frame_start) begin
      snap <= src_sel ? sw_val : time_val;
      for (int i = 0; i < NUM_FIELDS; i++) display_buf[i] <= work_buf[i];
    end
  end

  assign conv_start = (conv_state == CS_LOAD) && !conv_busy;

  bin2bcd_seq #(
    .FIELD_W (FIELD_W)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (snap[int'(conv_f)*FIELD_W +: FIELD_W]),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_state <= CS_IDLE;
      conv_f     <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) work_buf[i] <= 8'h00;
    end else begin
      case (conv_state)
        CS_IDLE: begin
          if (frame_start) begin
            conv_f     <= '0;
            conv_state <= CS_LOAD;
          end
        end
        CS_LOAD: begin
          if (!conv_busy) conv_state <= CS_WAIT;
        end
        CS_WAIT: begin
          if (conv_done) conv_state <= CS_STORE;
        end
        CS_STORE: begin
          work_buf[conv_f] <= conv_ovf ? {BCD_DASH, BCD_DASH} : conv_bcd;
          if (conv_f == FIW'(NUM_FIELDS - 1)) begin
            conv_state <= CS_DONE;
          end else begin
            conv_f     <= conv_f + 1'b1;
            conv_state <= CS_LOAD;
          end
        end
        CS_DONE: conv_state <= CS_IDLE;
        default: conv_state <= CS_IDLE;
      endcase
    end
  end

  // seconds_clk is from another domain: two flops to resynchronise, a third for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_s1       <= 1'b0;
      sc_s2       <= 1'b0;
      sc_s3       <= 1'b0;
      blink_phase <= 1'b1;
    end else begin
      sc_s1 <= seconds_clk;
      sc_s2 <= sc_s1;
      sc_s3 <= sc_s2;
      if (sc_s2 && !sc_s3) blink_phase <= ~blink_phase;
    end
  end

  always_comb begin
    cur_f    = FIW'(d >> 1);
    cur_bcd  = display_buf[cur_f];
    cur_nib  = d[0] ? cur_bcd[7:4] : cur_bcd[3:0];
    slot_seg = seg_of(cur_nib);
`ifdef SEG7_LZB_EN
    if ((cur_f == FIW'(NUM_FIELDS - 1)) && d[0] && (cur_nib == 4'd0)) slot_seg = SEG_BLANK;
`endif
    if (!blink_phase && mask_q[cur_f]) slot_seg = SEG_BLANK;
  end

  // First cycle of every slot drives no strobe so the previous digit cannot ghost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg    <= SEG_BLANK;
      dig_en <= '0;
      mask_q <= '0;
    end else if (presc == '0) begin
      seg    <= SEG_BLANK;
      dig_en <= '0;
      mask_q <= blink_mask;
    end else begin
      seg    <= slot_seg;
      dig_en <= ND'(1) << d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: cycle-level reference model, frame capture tables and hand-written corner sequences.
// Build with +define+SEG7_LZB_EN to exercise leading-zero blanking.
module tb_seg7_scan_display;
  import seg7_pkg::*;

  localparam int NF    = 3;
  localparam int FW    = 7;
  localparam int SD    = 8;
  localparam int ND    = 2 * NF;
  localparam int FRAME = ND * SD;
  localparam int TW    = NF * FW;
  localparam logic [6:0] REF_SEG [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef logic [ND-1:0][6:0] frame_t;
  typedef struct packed {
    logic [6:0] h;
    logic [6:0] m;
    logic [6:0] s;
    frame_t     segs;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          seconds_clk = 1'b0;
  logic          src_sel = 1'b0;
  logic [TW-1:0] time_val = '0;
  logic [TW-1:0] sw_val = '0;
  logic [NF-1:0] blink_mask = '0;
  logic [6:0]    seg;
  logic [ND-1:0] dig_en;
  logic          blink_phase;
  conv_state_e   conv_state;

  int vec_cnt = 0;
  int miscmp  = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .NUM_FIELDS (NF),
    .FIELD_W    (FW),
    .SCAN_DIV   (SD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seconds_clk (seconds_clk),
    .src_sel     (src_sel),
    .time_val    (time_val),
    .sw_val      (sw_val),
    .blink_mask  (blink_mask),
    .seg         (seg),
    .dig_en      (dig_en),
    .blink_phase (blink_phase),
    .conv_state  (conv_state)
  );

  function automatic void chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int field_of(input logic [TW-1:0] v, input int f);
    return int'(v[f*FW +: FW]);
  endfunction

  function automatic logic [6:0] ref_digit(input int v, input bit tens, input bit top);
    int dg;
    if (v >= 100) return 7'h40;
    dg = tens ? v / 10 : v % 10;
`ifdef SEG7_LZB_EN
    if (top && tens && dg == 0) return 7'h00;
`endif
    return REF_SEG[dg];
  endfunction

  // Reference model: frame k displays the source sampled at the start of frame k-1.
  int            n;
  int            pos, slot, pc, mf;
  int            m_disp [NF];
  int            m_pend [NF];
  logic [NF-1:0] m_mask;
  logic          m_phase;
  logic [2:0]    sc_h;
  logic [6:0]    exp_seg;
  logic [ND-1:0] exp_dig;
  logic          exp_phase;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0;
      for (int i = 0; i < NF; i++) begin
        m_disp[i] = 0;
        m_pend[i] = 0;
      end
      m_mask    = '0;
      m_phase   = 1'b1;
      sc_h      = '0;
      exp_seg   = '0;
      exp_dig   = '0;
      exp_phase = 1'b1;
    end else begin
      pos  = n % FRAME;
      slot = pos / SD;
      pc   = pos % SD;
      if (pos == 0) begin
        for (int i = 0; i < NF; i++) begin
          m_disp[i] = m_pend[i];
          m_pend[i] = src_sel ? field_of(sw_val, i) : field_of(time_val, i);
        end
      end
      if (pc == 0) begin
        m_mask  = blink_mask;
        exp_dig = '0;
        exp_seg = '0;
      end else begin
        mf      = slot / 2;
        exp_dig = ND'(1) << slot;
        exp_seg = ref_digit(m_disp[mf], (slot % 2) == 1, mf == NF - 1);
        if (!m_phase && m_mask[mf]) exp_seg = '0;
      end
      // sc_h[0..2] = seconds_clk seen 1..3 edges ago
      if (sc_h[1] && !sc_h[2]) m_phase = ~m_phase;
      sc_h      = {sc_h[1:0], seconds_clk};
      exp_phase = m_phase;
      n++;
    end
  end

  logic [6:0] cap   [ND];
  bit         cap_v [ND];

  always @(negedge clk) begin
    if (!reset) begin
      chk("dig_en", int'(dig_en), int'(exp_dig));
      chk("blink_phase", int'(blink_phase), int'(exp_phase));
      if (exp_dig != '0) chk("seg", int'(seg), int'(exp_seg));
      for (int i = 0; i < ND; i++) begin
        if (dig_en[i]) begin
          cap[i]   = seg;
          cap_v[i] = 1'b1;
        end
      end
    end
  end

  task automatic check_frame(input string tag, input int ncyc, input frame_t exp);
    for (int i = 0; i < ND; i++) cap_v[i] = 1'b0;
    repeat (ncyc) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk({tag, "_strobed"}, int'(cap_v[i]), 1);
      chk($sformatf("%s_digit%0d", tag, i), int'(cap[i]), int'(exp[i]));
    end
  endtask

  task automatic wait_pos(input int p);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < FRAME + 2 && !hit; k++) begin
      @(negedge clk);
      if (((n - 1) % FRAME) == p) hit = 1'b1;
    end
    chk("wait_pos_timeout", int'(hit), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, int'(seg), 0);
    chk({tag, "_dig_en"}, int'(dig_en), 0);
    chk({tag, "_blink_phase"}, int'(blink_phase), 1);
    chk({tag, "_conv_state"}, int'(conv_state), int'(CS_IDLE));
  endtask

  function automatic frame_t exp_of(input vec_t v);
    frame_t e;
    e = v.segs;
`ifdef SEG7_LZB_EN
    if (v.h < 7'd10) e[5] = 7'h00;
`endif
    return e;
  endfunction

  function automatic vec_t mk(input int h, input int m, input int s,
                              input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                              input logic [6:0] d3, input logic [6:0] d4, input logic [6:0] d5);
    vec_t v;
    v.h = 7'(h);
    v.m = 7'(m);
    v.s = 7'(s);
    v.segs[0] = d0; v.segs[1] = d1; v.segs[2] = d2;
    v.segs[3] = d3; v.segs[4] = d4; v.segs[5] = d5;
    return v;
  endfunction

  function automatic logic [TW-1:0] pack_val(input vec_t v);
    return {v.h, v.m, v.s};
  endfunction

  vec_t   vt [6];
  frame_t zf;
  frame_t bf;

  initial begin
    vt[0] = mk(12, 34, 56,  7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    vt[1] = mk(5, 0, 9,     7'h6F, 7'h3F, 7'h3F, 7'h3F, 7'h6D, 7'h3F);
    vt[2] = mk(23, 59, 120, 7'h40, 7'h40, 7'h6F, 7'h6D, 7'h4F, 7'h5B);
    vt[3] = mk(99, 100, 78, 7'h7F, 7'h07, 7'h40, 7'h40, 7'h6F, 7'h6F);
    vt[4] = mk(127, 10, 41, 7'h06, 7'h66, 7'h3F, 7'h06, 7'h40, 7'h40);
    vt[5] = mk(0, 1, 7,     7'h07, 7'h3F, 7'h06, 7'h3F, 7'h3F, 7'h3F);
    zf = mk(0, 0, 0, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F).segs;
`ifdef SEG7_LZB_EN
    zf[5] = 7'h00;
`endif

    // Power-on reset, then frame 0 shows the reset buffers and frame 1 the first snapshot.
    time_val = pack_val(vt[0]);
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    #1 reset = 1'b0;
    check_frame("frame0_zero", FRAME, zf);
    check_frame("frame1_time", FRAME, exp_of(vt[0]));

    for (int i = 0; i < 6; i++) begin
      time_val = pack_val(vt[i]);
      repeat (2 * FRAME) @(negedge clk);
      check_frame($sformatf("table%0d", i), FRAME + 2, exp_of(vt[i]));
    end

    // Blink: 3-cycle latency, then only the masked field goes dark.
    time_val   = pack_val(vt[0]);
    blink_mask = 3'b010;
    repeat (2 * FRAME) @(negedge clk);
    seconds_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("blink_before_latency", int'(blink_phase), 1);
    @(posedge clk);
    #1 chk("blink_after_latency", int'(blink_phase), 0);
    bf = exp_of(vt[0]);
    bf[2] = 7'h00;
    bf[3] = 7'h00;
    check_frame("blink_off", FRAME + 2, bf);
    seconds_clk = 1'b0;
    repeat (4) @(negedge clk);
    seconds_clk = 1'b1;
    repeat (4) @(negedge clk);
    chk("blink_restored", int'(blink_phase), 1);
    blink_mask = '0;

    // Source switch mid-frame: next frame still shows time, the one after shows the stopwatch.
    repeat (2 * FRAME) @(negedge clk);
    wait_pos(20);
    sw_val  = pack_val(vt[5]);
    src_sel = 1'b1;
    wait_pos(0);
    check_frame("src_next_frame", FRAME, exp_of(vt[0]));
    check_frame("src_frame_after", FRAME, exp_of(vt[5]));
    src_sel = 1'b0;

    // Reset mid-frame while blink_phase is 0.
    seconds_clk = 1'b0;
    repeat (4) @(negedge clk);
    seconds_clk = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_reset_phase", int'(blink_phase), 0);
    wait_pos(25);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    seconds_clk = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    check_frame("post_reset_zero", FRAME, zf);
    check_frame("post_reset_time", FRAME, exp_of(vt[0]));

    // Randomized traffic checked cycle by cycle against the model.
    for (int k = 0; k < 40; k++) begin
      time_val    = TW'($urandom);
      sw_val      = TW'($urandom);
      src_sel     = 1'($urandom_range(0, 1));
      blink_mask  = NF'($urandom_range(0, 7));
      seconds_clk = seconds_clk ^ 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
